// File: rtl/pcie_tlp_arb_pkg.sv
`default_nettype none
// ============================================================================
// pcie_tlp_arb_pkg
//   Shared types and helpers for the packet-aware PCIe TLP round-robin arbiter.
//   Revision: 1.0
// ============================================================================
package pcie_tlp_arb_pkg;

    localparam int c_DEF_TDATA_W = 512;
    localparam int c_DEF_TUSER_W = 10;
    localparam int c_DEF_NUM_SRC = 4;

    // Source-index width; never narrower than one bit.
    function automatic int SRC_ID_W(input int num_src);
        return (num_src <= 2) ? 1 : $clog2(num_src);
    endfunction

    localparam int c_DEF_SRC_W = SRC_ID_W(c_DEF_NUM_SRC);

    typedef struct packed {
        logic [c_DEF_TDATA_W-1:0]   tdata;
        logic [c_DEF_TDATA_W/8-1:0] tkeep;
        logic [c_DEF_TUSER_W-1:0]   tuser;
        logic                       tlast;
        logic [c_DEF_SRC_W-1:0]     src_id;
    } skid_entry_t;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/axis_skid_2entry.sv
`default_nettype none
// ============================================================================
// axis_skid_2entry
//   Two-entry skid buffer with a registered upstream ready and registered
//   downstream outputs; carries any packed payload type unchanged.
//   Revision: 1.0
// ============================================================================
module axis_skid_2entry #(
    parameter type T = logic [7:0]
) (
    input  logic clk,
    input  logic rst,
    input  logic i_valid,
    output logic o_ready,
    input  T     i_data,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data,
    output logic o_nonempty
);

    logic r_out_valid;
    logic r_skid_valid;
    logic r_in_ready;
    T     r_out_data;
    T     r_skid_data;

    logic w_in_fire;
    logic w_out_load;
    logic w_skid_valid_next;

    assign w_in_fire  = i_valid & r_in_ready;
    assign w_out_load = ~r_out_valid | i_ready;

    // The skid slot fills only when the output register is stalled.
    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (w_out_load) begin
            w_skid_valid_next = 1'b0;
        end else if (w_in_fire) begin
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            r_skid_valid <= w_skid_valid_next;
            r_in_ready   <= ~w_skid_valid_next;
            if (w_out_load) begin
                if (r_skid_valid) begin
                    r_out_valid <= 1'b1;
                    r_out_data  <= r_skid_data;
                end else begin
                    r_out_valid <= w_in_fire;
                    if (w_in_fire) begin
                        r_out_data <= i_data;
                    end
                end
            end else if (w_in_fire) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready    = r_in_ready;
    assign o_valid    = r_out_valid;
    assign o_data     = r_out_data;
    assign o_nonempty = r_out_valid | r_skid_valid;

endmodule
`default_nettype wire

// File: rtl/pcie_tlp_rr_arb.sv
`default_nettype none
// ============================================================================
// pcie_tlp_rr_arb
//   Packet-aware round-robin merge of NUM_SRC AXI-Stream TLP sources onto one
//   registered TX channel; a grant is held until the source's tlast beat.
//   Revision: 1.0
// ============================================================================
module pcie_tlp_rr_arb
    import pcie_tlp_arb_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int TDATA_WIDTH = 512,
    parameter int TUSER_WIDTH = 10,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_SRC-1:0]                 s_tvalid,
    output logic [NUM_SRC-1:0]                 s_tready,
    input  logic [NUM_SRC*TDATA_WIDTH-1:0]     s_tdata,
    input  logic [NUM_SRC*TDATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [NUM_SRC*TUSER_WIDTH-1:0]     s_tuser,
    input  logic [NUM_SRC-1:0]                 s_tlast,
    output logic                               m_tvalid,
    input  logic                               m_tready,
    output logic [TDATA_WIDTH-1:0]             m_tdata,
    output logic [TDATA_WIDTH/8-1:0]           m_tkeep,
    output logic [TUSER_WIDTH-1:0]             m_tuser,
    output logic                               m_tlast,
    output logic [$clog2(NUM_SRC)-1:0]         m_src_id,
    output logic                               busy,
    output logic [NUM_SRC*CNT_WIDTH-1:0]       pkt_cnt
);

    localparam int c_SRC_W  = SRC_ID_W(NUM_SRC);
    localparam int c_KEEP_W = TDATA_WIDTH / 8;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] tdata;
        logic [c_KEEP_W-1:0]    tkeep;
        logic [TUSER_WIDTH-1:0] tuser;
        logic                   tlast;
        logic [c_SRC_W-1:0]     src_id;
    } entry_t;

    // First requester strictly after 'last', wrapping around.
    function automatic logic [c_SRC_W-1:0] rr_pick(
        input logic [NUM_SRC-1:0] req,
        input logic [c_SRC_W-1:0] last
    );
        logic [c_SRC_W-1:0] pick;
        logic [c_SRC_W-1:0] idx_w;
        logic               found;
        int                 idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx   = (int'(last) + k) % NUM_SRC;
            idx_w = c_SRC_W'(idx);
            if (!found && req[idx_w]) begin
                pick  = idx_w;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [c_SRC_W-1:0] r_last_grant;
    logic [c_SRC_W-1:0] r_cur;
    logic [c_SRC_W-1:0] w_cand;
    logic [c_SRC_W-1:0] w_sel;
    logic [NUM_SRC-1:0] w_ready;
    logic               w_can_accept;
    logic               w_fire;
    logic               w_skid_nonempty;
    entry_t             w_in_entry;
    entry_t             w_out_entry;

    assign w_cand = rr_pick(s_tvalid, r_last_grant);

    always_comb begin
        w_state_next = r_state;
        w_ready      = '0;
        w_sel        = r_cur;
        w_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (|s_tvalid) begin
                    w_sel          = w_cand;
                    w_ready[w_cand] = w_can_accept;
                end
            end
            LOCKED: begin
                w_ready[r_cur] = w_can_accept;
            end
            default: ;
        endcase
        w_fire = |(s_tvalid & w_ready);
        if (w_fire) begin
            if (r_state == IDLE && !s_tlast[w_sel]) begin
                w_state_next = LOCKED;
            end else if (r_state == LOCKED && s_tlast[w_sel]) begin
                w_state_next = IDLE;
            end
        end
    end

    // A grant is committed only when its first beat is actually accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= c_SRC_W'(NUM_SRC - 1);
            r_cur        <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fire && r_state == IDLE) begin
                r_last_grant <= w_sel;
                r_cur        <= w_sel;
            end
        end
    end

    always_comb begin
        w_in_entry        = '0;
        w_in_entry.tdata  = s_tdata[int'(w_sel)*TDATA_WIDTH +: TDATA_WIDTH];
        w_in_entry.tkeep  = s_tkeep[int'(w_sel)*c_KEEP_W +: c_KEEP_W];
        w_in_entry.tuser  = s_tuser[int'(w_sel)*TUSER_WIDTH +: TUSER_WIDTH];
        w_in_entry.tlast  = s_tlast[w_sel];
        w_in_entry.src_id = w_sel;
    end

    axis_skid_2entry #(
        .T (entry_t)
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_fire),
        .o_ready    (w_can_accept),
        .i_data     (w_in_entry),
        .o_valid    (m_tvalid),
        .i_ready    (m_tready),
        .o_data     (w_out_entry),
        .o_nonempty (w_skid_nonempty)
    );

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_pkt_cnt
        logic [CNT_WIDTH-1:0] r_cnt;
        logic                 w_inc;

        assign w_inc = s_tvalid[i] & w_ready[i] & s_tlast[i] & ~(&r_cnt);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_inc) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
            end
        end

        assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
    end

    assign s_tready = w_ready;
    assign m_tdata  = w_out_entry.tdata;
    assign m_tkeep  = w_out_entry.tkeep;
    assign m_tuser  = w_out_entry.tuser;
    assign m_tlast  = w_out_entry.tlast;
    assign m_src_id = w_out_entry.src_id;
    assign busy     = (r_state == LOCKED) | w_skid_nonempty;

endmodule
`default_nettype wire

// File: tb/tb_pcie_tlp_rr_arb.sv
`default_nettype none
// ============================================================================
// tb_pcie_tlp_rr_arb
//   Randomized bench with a packet-level reference model and scoreboard.
//   Revision: 1.0
// ============================================================================
module tb_pcie_tlp_rr_arb;

    localparam int c_NS  = 4;
    localparam int c_TDW = 32;
    localparam int c_TUW = 4;
    localparam int c_CW  = 4;
    localparam int c_KW  = c_TDW / 8;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [c_NS-1:0]       s_tvalid;
    logic [c_NS-1:0]       s_tready;
    logic [c_NS*c_TDW-1:0] s_tdata;
    logic [c_NS*c_KW-1:0]  s_tkeep;
    logic [c_NS*c_TUW-1:0] s_tuser;
    logic [c_NS-1:0]       s_tlast;
    logic                  m_tvalid;
    logic                  m_tready;
    logic [c_TDW-1:0]      m_tdata;
    logic [c_KW-1:0]       m_tkeep;
    logic [c_TUW-1:0]      m_tuser;
    logic                  m_tlast;
    logic [1:0]            m_src_id;
    logic                  busy;
    logic [c_NS*c_CW-1:0]  pkt_cnt;

    always #5 clk = ~clk;

    pcie_tlp_rr_arb #(
        .NUM_SRC     (c_NS),
        .TDATA_WIDTH (c_TDW),
        .TUSER_WIDTH (c_TUW),
        .CNT_WIDTH   (c_CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tuser  (s_tuser),
        .s_tlast  (s_tlast),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tuser  (m_tuser),
        .m_tlast  (m_tlast),
        .m_src_id (m_src_id),
        .busy     (busy),
        .pkt_cnt  (pkt_cnt)
    );

    typedef struct {
        logic [c_TDW-1:0] data;
        logic [c_KW-1:0]  keep;
        logic [c_TUW-1:0] user;
        logic             last;
        int               gap;
    } beat_t;

    typedef struct {
        logic [c_TDW-1:0] data;
        logic [c_KW-1:0]  keep;
        logic [c_TUW-1:0] user;
        logic             last;
        int               src;
    } exp_t;

    beat_t src_q [c_NS][$];
    int    gap_cnt [c_NS];
    exp_t  exp_q [$];
    int    mdl_last;
    int    mdl_cur;
    bit    mdl_locked;
    int    mdl_cnt [c_NS];
    int    n_checks;
    int    n_pass;
    int    cyc;
    int    rdy_mode;
    int    out_src_log [$];
    int    out_cyc_log [$];
    int    first_acc;
    int    first_mv;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Winner = requester at smallest cyclic distance past the last grant.
    function automatic int rr_ref(input logic [c_NS-1:0] req, input int last);
        int best;
        int best_d;
        int d;
        best   = -1;
        best_d = c_NS + 1;
        for (int i = 0; i < c_NS; i++) begin
            if (req[i]) begin
                d = (i - last - 1 + 2 * c_NS) % c_NS;
                if (d < best_d) begin
                    best_d = d;
                    best   = i;
                end
            end
        end
        return best;
    endfunction

    function automatic bit all_empty();
        bit e;
        e = (exp_q.size() == 0);
        for (int i = 0; i < c_NS; i++) if (src_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < c_NS; i++) begin
            src_q[i].delete();
            gap_cnt[i] = 0;
            mdl_cnt[i] = 0;
        end
        exp_q.delete();
        mdl_last   = c_NS - 1;
        mdl_cur    = 0;
        mdl_locked = 1'b0;
    endtask

    task automatic add_pkt(input int s, input int len, input int gap_first, input bit rnd_gap);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = $urandom();
            b.keep = c_KW'($urandom());
            b.user = c_TUW'($urandom());
            b.last = (k == len - 1);
            b.gap  = rnd_gap ? int'($urandom_range(0, 2)) : ((k == 0 && len > 1) ? gap_first : 0);
            src_q[s].push_back(b);
        end
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < c_NS; i++) begin
            if (src_q[i].size() > 0 && gap_cnt[i] == 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i*c_TDW +: c_TDW] = src_q[i][0].data;
                s_tkeep[i*c_KW +: c_KW]   = src_q[i][0].keep;
                s_tuser[i*c_TUW +: c_TUW] = src_q[i][0].user;
                s_tlast[i]                = src_q[i][0].last;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tlast[i]  = 1'b0;
            end
        end
        case (rdy_mode)
            1:       m_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       m_tready = ($urandom_range(0, 3) != 0);
            default: m_tready = 1'b1;
        endcase
    endtask

    task automatic cycle();
        logic [c_NS-1:0] fire;
        logic [c_NS-1:0] mask;
        int              src;
        int              exp_src;
        beat_t           b;
        exp_t            e;
        @(negedge clk);
        fire = s_tvalid & s_tready;
        chk_eq("m_tvalid", m_tvalid, exp_q.size() > 0);
        chk_eq("busy", busy, mdl_locked || exp_q.size() > 0);
        chk_eq("skid_occ_le2", exp_q.size() <= 2, 1);
        chk_eq("ready_onehot0", $countones(s_tready) <= 1, 1);
        if (mdl_locked) begin
            mask = '1;
            mask[mdl_cur] = 1'b0;
            chk_eq("lock_excl", s_tready & mask, 0);
        end
        if (m_tvalid && first_mv < 0) first_mv = cyc;
        if (m_tvalid && m_tready) begin
            out_src_log.push_back(int'(m_src_id));
            out_cyc_log.push_back(cyc);
            chk_eq("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk_eq("m_tdata", m_tdata, e.data);
                chk_eq("m_keep_user_last", {m_tkeep, m_tuser, m_tlast}, {e.keep, e.user, e.last});
                chk_eq("m_src_id", m_src_id, e.src);
            end
        end
        if (fire != 0) begin
            chk_eq("in_fire_onehot", $countones(fire), 1);
            src = 0;
            for (int i = c_NS - 1; i >= 0; i--) if (fire[i]) src = i;
            b = src_q[src].pop_front();
            if (!mdl_locked) begin
                exp_src = rr_ref(s_tvalid, mdl_last);
                chk_eq("rr_pick", src, exp_src);
                mdl_last = exp_src;
                if (!b.last) begin
                    mdl_locked = 1'b1;
                    mdl_cur    = exp_src;
                end
            end else begin
                chk_eq("no_interleave", src, mdl_cur);
                if (b.last) mdl_locked = 1'b0;
            end
            if (b.last && mdl_cnt[src] < (1 << c_CW) - 1) mdl_cnt[src]++;
            e.data = b.data;
            e.keep = b.keep;
            e.user = b.user;
            e.last = b.last;
            e.src  = src;
            exp_q.push_back(e);
            gap_cnt[src] = b.gap;
            if (first_acc < 0) first_acc = cyc;
        end
        for (int i = 0; i < c_NS; i++) if (!s_tvalid[i] && gap_cnt[i] > 0) gap_cnt[i]--;
        @(posedge clk);
        #1;
        cyc++;
        drive_inputs();
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        drive_inputs();
        while (!all_empty() && n < max_cyc) begin
            cycle();
            n++;
        end
        chk_eq("drained", all_empty(), 1);
    endtask

    task automatic scen_start();
        out_src_log.delete();
        out_cyc_log.delete();
        first_acc = -1;
        first_mv  = -1;
    endtask

    task automatic chk_seq(input string tag, input int n, input logic [31:0] seq);
        chk_eq({tag, "_len"}, out_src_log.size(), n);
        for (int k = 0; k < n && k < out_src_log.size(); k++)
            chk_eq($sformatf("%s_src%0d", tag, k), out_src_log[k], seq[4*k +: 4]);
    endtask

    task automatic check_cnts();
        for (int i = 0; i < c_NS; i++)
            chk_eq($sformatf("pkt_cnt%0d", i), pkt_cnt[i*c_CW +: c_CW], mdl_cnt[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        cyc      = 0;
        rdy_mode = 0;
        rst      = 1'b1;
        s_tvalid = '1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        s_tlast  = '0;
        m_tready = 1'b1;
        mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_eq("rst_m_tvalid", m_tvalid, 0);
        chk_eq("rst_s_tready", s_tready, 0);
        chk_eq("rst_busy", busy, 0);
        chk_eq("rst_pkt_cnt", pkt_cnt, 0);
        chk_eq("rst_m_tdata", m_tdata, 0);
        s_tvalid = '0;
        rst      = 1'b0;

        // Simultaneous single-beat packets from every source.
        scen_start();
        for (int i = 0; i < c_NS; i++) add_pkt(i, 1, 0, 1'b0);
        drain(50);
        chk_seq("s1", 4, 32'h3210);
        chk_eq("s1_latency", first_mv - first_acc, 1);
        if (out_cyc_log.size() == 4) chk_eq("s1_b2b", out_cyc_log[3] - out_cyc_log[0], 3);
        check_cnts();

        // Multi-beat packet; a competitor arrives mid-packet.
        scen_start();
        add_pkt(1, 4, 0, 1'b0);
        add_pkt(2, 2, 0, 1'b0);
        gap_cnt[2] = 1;
        drain(50);
        chk_seq("s2", 6, 32'h221111);
        if (out_cyc_log.size() == 6) chk_eq("s2_b2b", out_cyc_log[5] - out_cyc_log[0], 5);

        // Bubble inside a locked packet must not release the grant.
        scen_start();
        add_pkt(0, 3, 2, 1'b0);
        add_pkt(3, 1, 0, 1'b0);
        gap_cnt[3] = 1;
        drain(50);
        chk_seq("s3", 4, 32'h3000);

        // Continuous 8-beat traffic against a 1,0,0,1 ready pattern.
        scen_start();
        rdy_mode = 1;
        for (int r = 0; r < 2; r++) for (int i = 0; i < c_NS; i++) add_pkt(i, 8, 0, 1'b0);
        drain(400);
        check_cnts();
        rdy_mode = 0;

        // Asynchronous reset in the middle of a 5-beat packet.
        scen_start();
        add_pkt(1, 5, 0, 1'b0);
        drive_inputs();
        for (int n = 0; n < 20 && src_q[1].size() > 3; n++) cycle();
        chk_eq("s5_two_beats_in", src_q[1].size(), 3);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("s5_m_tvalid", m_tvalid, 0);
        chk_eq("s5_pkt_cnt", pkt_cnt, 0);
        chk_eq("s5_busy", busy, 0);
        chk_eq("s5_s_tready", s_tready, 0);
        mdl_reset();
        s_tvalid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        scen_start();
        add_pkt(2, 1, 0, 1'b0);
        add_pkt(0, 1, 0, 1'b0);
        drain(50);
        chk_seq("s5", 2, 32'h20);

        // Counter saturation with a 4-bit counter.
        for (int k = 0; k < 17; k++) add_pkt(0, 1, 0, 1'b0);
        drain(100);
        chk_eq("cnt_sat", pkt_cnt[0 +: c_CW], 15);
        check_cnts();

        // Randomized traffic with random gaps and random backpressure.
        scen_start();
        rdy_mode = 2;
        for (int k = 0; k < 60; k++)
            add_pkt(int'($urandom_range(0, c_NS - 1)), int'($urandom_range(1, 6)), 0, 1'b1);
        for (int i = 0; i < c_NS; i++) gap_cnt[i] = int'($urandom_range(0, 3));
        drain(4000);
        check_cnts();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pcie_tlp_rr_arb.md
Name: pcie_tlp_rr_arb

Overview:
- Packet-aware round-robin arbiter that merges NUM_SRC AXI-Stream TLP sources onto one PCIe TX channel. Example: several port AFUs, or an AFU's TX A and TX B streams, sharing one upstream TX A link toward the PF/VF mux.
- A packet is never interleaved. A grant is held from the first beat until that source's tlast beat is accepted.
- The output is fully registered through a 2-entry skid buffer, so it sustains full throughput with a registered tready.

Parameters:
- NUM_SRC, 4: number of requesting sources, legal range 2..8.
- TDATA_WIDTH, 512: tdata width in bits.
- TUSER_WIDTH, 10: tuser width in bits; carried through unmodified.
- CNT_WIDTH, 16: width of the per-source packet counters.

Ports:
- clk, in, 1: sole clock.
- rst, in, 1: asynchronous reset, active-high.
- s_tvalid, in, NUM_SRC: per-source valid.
- s_tready, out, NUM_SRC: per-source ready.
- s_tdata, in, NUM_SRC*TDATA_WIDTH: source i occupies slice [i*TDATA_WIDTH +: TDATA_WIDTH].
- s_tkeep, in, NUM_SRC*TDATA_WIDTH/8: per-source byte enables.
- s_tuser, in, NUM_SRC*TUSER_WIDTH: per-source sideband.
- s_tlast, in, NUM_SRC: per-source end of packet.
- m_tvalid, out, 1: merged output valid.
- m_tready, in, 1: downstream ready.
- m_tdata, out, TDATA_WIDTH: merged data.
- m_tkeep, out, TDATA_WIDTH/8: merged byte enables.
- m_tuser, out, TUSER_WIDTH: merged sideband.
- m_tlast, out, 1: merged end of packet.
- m_src_id, out, $clog2(NUM_SRC): index of the source that produced the current output beat.
- busy, out, 1: high while in LOCKED state or while the skid buffer is non-empty.
- pkt_cnt, out, NUM_SRC*CNT_WIDTH: per-source count of accepted tlast beats; saturates at all-ones.

Behaviour:
- Reset (async assert):
  - m_tvalid=0, skid buffer empty, s_tready=0, busy=0, pkt_cnt=0.
  - FSM goes to IDLE; last_grant=NUM_SRC-1, so source 0 has highest priority after reset.
  - Data outputs go to 0.
  - Reset mid-packet discards the partial packet; no tlast is fabricated.
  - Reset deassertion is synchronized externally; the block needs no further handling.
- Skid buffer:
  - 2 entries.
  - can_accept = (occupancy < 2) registered equivalent, i.e. at most 1 entry occupied, or 2 entries with m_tready. Implementations use the standard registered-ready skid form.
  - An accepted input beat appears on m_* the next cycle at the earliest; latency is 1 cycle.
  - Throughput is 1 beat/clk while m_tready=1.
- FSM:
  - IDLE:
    - Grant candidate g = first i with s_tvalid[i]=1, searching from (last_grant+1) mod NUM_SRC upward with wrap.
    - No valid source: stay in IDLE, s_tready=0.
    - Otherwise s_tready[g]=can_accept and all other s_tready bits are 0.
    - If the beat is accepted: last_grant<=g.
    - If the accepted beat has tlast=1, stay in IDLE (single-beat packet). Otherwise go to LOCKED with cur<=g.
    - If can_accept=0, no grant is committed and the candidate is re-evaluated the next cycle. This allows a higher-RR-priority source to arrive and win.
  - LOCKED:
    - s_tready[cur]=can_accept; all others 0.
    - s_tvalid[cur]=0 (bubble) keeps the lock; no other source is granted.
    - When a tlast beat from cur is accepted, go to IDLE.
- Fairness: each source receives at most one packet per RR round while others are waiting. Worst-case wait is (NUM_SRC-1) packets.
- m_src_id travels with the beat through the skid buffer.
- pkt_cnt[i] increments on input-side acceptance of a tlast beat from source i. At all-ones it holds.
- AXIS rule: a source may not retract tvalid. The arbiter never deasserts s_tready[cur] mid-packet except for can_accept backpressure.
- busy is registered: it reflects FSM and occupancy after each edge.

Decomposition:
- Package pcie_tlp_arb_pkg holds:
  - the SRC_ID_W function ($clog2 with minimum 1);
  - a typedef for the skid entry struct {tdata, tkeep, tuser, tlast, src_id}, parameterized by localparams;
  - the FSM enum {IDLE, LOCKED}.
- Sub-module axis_skid_2entry: generic 2-entry registered skid buffer on the entry struct (valid/ready in, valid/ready out).
- The RR pick is a function in the arbiter body; it is not a separate module.

Test Plan:
- Reset, then sources 0..3 each present one single-beat packet simultaneously with m_tready=1 → output m_src_id sequence 0,1,2,3 on consecutive cycles. First m_tvalid appears 1 cycle after the first accept. pkt_cnt = 1,1,1,1.
- Source 1 sends a 4-beat packet; source 2 asserts valid at beat 2 → all 4 source-1 beats are contiguous on m_* with m_tlast only on beat 4. Source 2's first beat follows at the very next output slot. s_tready[2]=0 throughout.
- Source 0 holds a 3-beat packet with a 2-cycle bubble after beat 1 while source 3 is valid → the lock is held and source 3 is not granted until source 0's tlast is accepted. Output order is 0,0,0,3.
- m_tready toggles 1,0,0,1 every cycle during continuous 8-beat traffic from all sources → no beat lost or duplicated, the scoreboard matches the input order per grant, and the skid buffer never exceeds 2 entries.
- Assert rst for 1 cycle mid-way through a 5-beat packet (after beat 2) → m_tvalid=0 and pkt_cnt=0 immediately (asynchronous). After release, the next grant goes to source 0 if it is valid.
- Preload pkt_cnt[0] near the top (CNT_WIDTH=4, send 17 packets) → pkt_cnt[0] reads 15 and holds.
